// File: rtl/operand_fetch.sv
// Operand fetch stage: 8x16 register file, sequential A/B reads, valid/ready issue to the shifter.
// Optional write-through forwarding on reads: define OPERAND_FETCH_WRITE_BYPASS_EN.
module operand_fetch #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             write,
  input  logic [AW-1:0]    writenum,
  input  logic [WIDTH-1:0] data_in,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AW-1:0]    rn,
  input  logic [AW-1:0]    rm,
  input  logic [1:0]       shift_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [1:0]       out_shift
);

  typedef enum logic [1:0] {StIdle, StReadA, StReadB, StIssue} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   regs_q [NREGS];
  logic [AW-1:0]      rn_q, rm_q;
  logic [1:0]         shift_q;
  logic [WIDTH-1:0]   out_a_q, out_b_q;
  logic [1:0]         out_shift_q;
  logic [AW-1:0]      read_idx;
  logic [WIDTH-1:0]   read_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else if (write) begin
      regs_q[writenum] <= data_in;
    end
  end

  always_comb begin
    read_idx = (state_q == StReadA) ? rn_q : rm_q;
    read_val = regs_q[read_idx];
`ifdef OPERAND_FETCH_WRITE_BYPASS_EN
    if (write && (writenum == read_idx)) read_val = data_in;
`endif
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid) state_d = StReadA;
      StReadA: state_d = StReadB;
      StReadB: state_d = StIssue;
      StIssue: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rn_q        <= '0;
      rm_q        <= '0;
      shift_q     <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_shift_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && req_valid) begin
        rn_q    <= rn;
        rm_q    <= rm;
        shift_q <= shift_in;
      end
      if (state_q == StReadA) out_a_q <= read_val;
      if (state_q == StReadB) begin
        out_b_q     <= read_val;
        out_shift_q <= shift_q;
      end
    end
  end

  // Handshake flags decode from state only, no input-to-output path.
  assign req_ready = (state_q == StIdle);
  assign out_valid = (state_q == StIssue);
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_shift = out_shift_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus randomized traffic,
// every cycle compared against a timestamp-based behavioural model.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        write = 1'b0;
  logic [2:0]  writenum = '0;
  logic [15:0] data_in = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  rn = '0;
  logic [2:0]  rm = '0;
  logic [1:0]  shift_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_a, out_b;
  logic [1:0]  out_shift;

  int checks = 0;
  int errors = 0;

  operand_fetch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .write     (write),
    .writenum  (writenum),
    .data_in   (data_in),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .rn        (rn),
    .rm        (rm),
    .shift_in  (shift_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_shift (out_shift)
  );

  always #5 clk = ~clk;

  // Reference model: a request accepted at cycle t captures A at t+1, B at t+2,
  // and stays valid until a cycle with out_ready.
  logic [15:0] m_regs [8];
  int          cyc = 0;
  int          t_acc = 0;
  logic        m_busy = 1'b0;
  logic        m_valid = 1'b0;
  logic [2:0]  m_rn, m_rm;
  logic [1:0]  m_sh;
  logic [15:0] m_a = '0, m_b = '0;
  logic [1:0]  m_shift = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [2:0] idx);
`ifdef OPERAND_FETCH_WRITE_BYPASS_EN
    if (write && writenum == idx) return data_in;
`endif
    return m_regs[idx];
  endfunction

  function automatic logic [15:0] shifter(input logic [15:0] v, input logic [1:0] sh);
    case (sh)
      2'b00:   return v;
      2'b01:   return v << 1;
      2'b10:   return v >> 1;
      default: return {v[15], v[15:1]};
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_busy = 1'b0; m_valid = 1'b0;
    m_a = '0; m_b = '0; m_shift = '0;
  endtask

  task automatic model_edge();
    cyc++;
    if (m_busy) begin
      if (cyc == t_acc + 1) m_a = model_read(m_rn);
      else if (cyc == t_acc + 2) begin
        m_b = model_read(m_rm);
        m_shift = m_sh;
        m_valid = 1'b1;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
        m_busy = 1'b0;
      end
    end else if (req_valid) begin
      m_rn = rn; m_rm = rm; m_sh = shift_in;
      m_busy = 1'b1;
      t_acc = cyc;
    end
    if (write) m_regs[writenum] = data_in;
  endtask

  task automatic compare_all();
    check_eq("req_ready", 32'(req_ready), 32'(!m_busy));
    check_eq("out_valid", 32'(out_valid), 32'(m_valid));
    check_eq("out_a", 32'(out_a), 32'(m_a));
    check_eq("out_b", 32'(out_b), 32'(m_b));
    check_eq("out_shift", 32'(out_shift), 32'(m_shift));
  endtask

  task automatic step(input logic w, input logic [2:0] wn, input logic [15:0] din,
                      input logic rv, input logic [2:0] a, input logic [2:0] b,
                      input logic [1:0] sh, input logic ordy);
    @(negedge clk);
    write = w; writenum = wn; data_in = din;
    req_valid = rv; rn = a; rm = b; shift_in = sh; out_ready = ordy;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle_step(input logic ordy);
    step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 2'b00, ordy);
  endtask

  initial begin
    model_reset();
    // Reset then idle
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk) rst_n = 1'b1;
    #1;
    compare_all();

    // Basic fetch with backpressure: R3=0x82C5, R5=0x0007, arithmetic right
    step(1'b1, 3'd3, 16'b1000001011000101, 1'b0, 3'd0, 3'd0, 2'b00, 1'b0);
    step(1'b1, 3'd5, 16'h0007, 1'b0, 3'd0, 3'd0, 2'b00, 1'b0);
    step(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 3'd5, 2'b11, 1'b0);
    idle_step(1'b0);
    idle_step(1'b0);
    check_eq("basic_valid", 32'(out_valid), 32'd1);
    check_eq("basic_a", 32'(out_a), 32'h82C5);
    check_eq("basic_b", 32'(out_b), 32'h0007);
    check_eq("basic_shifted", 32'(shifter(out_b, out_shift)), 32'h0003);
    repeat (3) idle_step(1'b0);
    check_eq("hold_a", 32'(out_a), 32'h82C5);
    idle_step(1'b1);
    check_eq("release_ready", 32'(req_ready), 32'd1);

    // Busy rejection: second request pulsed during READ_B
    step(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 3'd3, 2'b01, 1'b0);
    idle_step(1'b0);
    step(1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 3'd1, 2'b10, 1'b0);
    idle_step(1'b1);
    check_eq("busy_a", 32'(out_a), 32'h0007);
    check_eq("busy_shift", 32'(out_shift), 32'd1);
    repeat (3) idle_step(1'b1);

    // Same-cycle write to R5 while it is being read
    step(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 3'd5, 2'b00, 1'b0);
    idle_step(1'b0);
    step(1'b1, 3'd5, 16'h1234, 1'b0, 3'd0, 3'd0, 2'b00, 1'b0);
`ifdef OPERAND_FETCH_WRITE_BYPASS_EN
    check_eq("bypass_b", 32'(out_b), 32'h1234);
`else
    check_eq("bypass_b", 32'(out_b), 32'h0007);
`endif
    // A later write must not disturb held operands
    step(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 3'd0, 2'b00, 1'b0);
    check_eq("held_a", 32'(out_a), 32'h82C5);
    idle_step(1'b1);

    // Reset mid-operation during READ_A
    step(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 3'd3, 2'b11, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk) rst_n = 1'b1;
    step(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 3'd5, 2'b01, 1'b0);
    repeat (3) idle_step(1'b0);
    check_eq("post_reset_a", 32'(out_a), 32'h0);
    check_eq("post_reset_valid", 32'(out_valid), 32'd1);
    idle_step(1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom),
           1'($urandom_range(0, 1)), 3'($urandom), 3'($urandom), 2'($urandom),
           1'($urandom_range(0, 4) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
